// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: oversampled start/data/parity/stop sequencing with majority voting.
// Optional saturating error counter (err_cnt/err_clr) built only when UART_RX_ERR_CNT_EN is defined.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  par_err,
`ifdef UART_RX_ERR_CNT_EN
  input  logic                  err_clr,
  output logic [7:0]            err_cnt,
`endif
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  sampled_bit,
  output logic                  par_chk_en,
  output logic                  data_valid,
  output logic                  stp_err,
  output logic                  par_err_o,
  output logic                  strt_glitch
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic [2:0]            samp_q, samp_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_chk_en_q, par_chk_en_d;
  logic                  par_pend_q, par_pend_d;
  logic                  par_flag_q, par_flag_d;
  logic                  data_valid_q, data_valid_d;
  logic                  stp_err_q, stp_err_d;
  logic                  par_err_o_q, par_err_o_d;
  logic                  strt_glitch_q, strt_glitch_d;

  logic [PRESC_W-1:0]    half_cnt;
  logic [PRESC_W-1:0]    last_cnt;
  logic                  is_last;
  logic                  is_dec;
  logic                  majority;

  // Sample points sit symmetrically around mid-bit; the vote is taken one edge after the third sample.
  assign half_cnt = presc_q >> 1;
  assign last_cnt = presc_q - PRESC_W'(1);
  assign is_last  = (edge_cnt_q == last_cnt);
  assign is_dec   = (edge_cnt_q == half_cnt + PRESC_W'(2));
  assign majority = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  always_comb begin
    state_d       = state_q;
    edge_cnt_d    = is_last ? '0 : edge_cnt_q + PRESC_W'(1);
    bit_cnt_d     = bit_cnt_q;
    presc_d       = presc_q;
    par_en_d      = par_en_q;
    samp_d        = samp_q;
    sampled_bit_d = sampled_bit_q;
    p_data_d      = p_data_q;
    par_chk_en_d  = 1'b0;
    par_pend_d    = par_chk_en_q;
    par_flag_d    = par_flag_q;
    data_valid_d  = 1'b0;
    stp_err_d     = 1'b0;
    par_err_o_d   = 1'b0;
    strt_glitch_d = 1'b0;

    if (state_q != IDLE) begin
      if (edge_cnt_q == half_cnt - PRESC_W'(1)) samp_d[0] = RX_IN;
      if (edge_cnt_q == half_cnt)               samp_d[1] = RX_IN;
      if (edge_cnt_q == half_cnt + PRESC_W'(1)) samp_d[2] = RX_IN;
      if (is_dec)                               sampled_bit_d = majority;
    end

    // The checker answers one cycle after the strobe; hold its verdict until the stop decision.
    if (par_pend_q) par_flag_d = par_err;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!RX_IN) begin
          state_d    = START;
          presc_d    = Prescale;
          par_en_d   = PAR_EN;
          par_flag_d = 1'b0;
        end
      end
      START: begin
        if (is_dec && majority) begin
          strt_glitch_d = 1'b1;
          state_d       = IDLE;
          edge_cnt_d    = '0;
        end else if (is_last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (is_dec) p_data_d[bit_cnt_q] = majority;
        if (is_last) begin
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (is_dec)  par_chk_en_d = 1'b1;
        if (is_last) state_d = STOP;
      end
      STOP: begin
        // Leave before the end of the stop bit so a back-to-back start edge is not missed.
        if (is_dec) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          if (!majority)       stp_err_d    = 1'b1;
          else if (par_flag_q) par_err_o_d  = 1'b1;
          else                 data_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      edge_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      presc_q       <= '0;
      par_en_q      <= 1'b0;
      samp_q        <= '0;
      sampled_bit_q <= 1'b0;
      p_data_q      <= '0;
      par_chk_en_q  <= 1'b0;
      par_pend_q    <= 1'b0;
      par_flag_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      stp_err_q     <= 1'b0;
      par_err_o_q   <= 1'b0;
      strt_glitch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      presc_q       <= presc_d;
      par_en_q      <= par_en_d;
      samp_q        <= samp_d;
      sampled_bit_q <= sampled_bit_d;
      p_data_q      <= p_data_d;
      par_chk_en_q  <= par_chk_en_d;
      par_pend_q    <= par_pend_d;
      par_flag_q    <= par_flag_d;
      data_valid_q  <= data_valid_d;
      stp_err_q     <= stp_err_d;
      par_err_o_q   <= par_err_o_d;
      strt_glitch_q <= strt_glitch_d;
    end
  end

  assign P_DATA      = p_data_q;
  assign sampled_bit = sampled_bit_q;
  assign par_chk_en  = par_chk_en_q;
  assign data_valid  = data_valid_q;
  assign stp_err     = stp_err_q;
  assign par_err_o   = par_err_o_q;
  assign strt_glitch = strt_glitch_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = 8'd0;
    else if ((stp_err_q | par_err_o_q | strt_glitch_q) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) err_cnt_q <= 8'd0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl: table of whole frames plus back-to-back, glitch and reset-abort sequences.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       par_err;
  logic [7:0] P_DATA;
  logic       sampled_bit, par_chk_en, data_valid, stp_err, par_err_o, strt_glitch;
`ifdef UART_RX_ERR_CNT_EN
  logic       err_clr;
  logic [7:0] err_cnt;
`endif

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .par_err(par_err),
`ifdef UART_RX_ERR_CNT_EN
    .err_clr(err_clr), .err_cnt(err_cnt),
`endif
    .P_DATA(P_DATA), .sampled_bit(sampled_bit), .par_chk_en(par_chk_en),
    .data_valid(data_valid), .stp_err(stp_err), .par_err_o(par_err_o),
    .strt_glitch(strt_glitch)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor and parity-checker model (answers the cycle after par_chk_en).
  int         dv_cnt = 0, perr_cnt = 0, stp_cnt = 0, gl_cnt = 0, pchk_cnt = 0;
  int         last_dv_cyc = 0;
  logic [7:0] dv_log [64];
  logic       perr_model = 1'b0;
  logic       pchk_prev;

  initial begin
    par_err   = 1'b0;
    pchk_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (data_valid) begin
        dv_log[dv_cnt % 64] = P_DATA;
        last_dv_cyc = cyc;
        dv_cnt++;
      end
      if (par_err_o)   perr_cnt++;
      if (stp_err)     stp_cnt++;
      if (strt_glitch) gl_cnt++;
      if (par_chk_en)  pchk_cnt++;
      par_err   = pchk_prev ? perr_model : 1'b0;
      pchk_prev = par_chk_en;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_bit(input logic val, input int n);
    RX_IN = val;
    repeat (n) @(negedge CLK);
  endtask

  // Config inputs are scrambled mid-frame; the DUT must use the values latched at the start edge.
  task automatic send_frame(input int p, input logic pe, input logic [7:0] d,
                            input logic pb, input logic sb, output int c0);
    Prescale = 6'(p);
    PAR_EN   = pe;
    RX_IN    = 1'b0;
    @(negedge CLK);
    c0 = cyc;
    repeat (p - 1) @(negedge CLK);
    Prescale = (p == 8) ? 6'd16 : 6'd8;
    PAR_EN   = ~pe;
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pb, p);
    Prescale = 6'(p);
    PAR_EN   = pe;
    drive_bit(sb, p);
    RX_IN = 1'b1;
  endtask

  typedef struct {
    int         presc;
    logic       pe;
    logic [7:0] data;
    logic       pbit;
    logic       sbit;
    logic       perr;
    int         e_dv;
    int         e_perr;
    int         e_stp;
    int         e_gl;
    int         e_pchk;
    logic [7:0] e_pdata;
    int         e_lat;
  } vec_t;

  vec_t vecs [5];
  int   b_dv, b_perr, b_stp, b_gl, b_pchk;
  int   c0, c1;
  int   exp_err;

  task automatic snap();
    b_dv = dv_cnt; b_perr = perr_cnt; b_stp = stp_cnt; b_gl = gl_cnt; b_pchk = pchk_cnt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd16;
`ifdef UART_RX_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    // presc pe data pbit sbit perr | dv perr stp gl pchk pdata latency
    vecs[0] = '{8,  1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 1, 8'hA5, 87};
    vecs[1] = '{8,  1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 0, 1, 0, 0, 1, 8'h5A, 0};
    vecs[2] = '{32, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 0, 0, 1, 1, 1, 8'h0F, 0};
    vecs[3] = '{16, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 0, 8'h3C, 155};
    vecs[4] = '{32, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 0, 8'hC3, 307};

    repeat (3) @(negedge CLK);
    check("rst_p_data",      int'(P_DATA), 0);
    check("rst_data_valid",  int'(data_valid), 0);
    check("rst_stp_err",     int'(stp_err), 0);
    check("rst_par_err_o",   int'(par_err_o), 0);
    check("rst_strt_glitch", int'(strt_glitch), 0);
    check("rst_par_chk_en",  int'(par_chk_en), 0);
    check("rst_sampled_bit", int'(sampled_bit), 0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    exp_err = 0;
    for (int i = 0; i < 5; i++) begin
      snap();
      perr_model = vecs[i].perr;
      send_frame(vecs[i].presc, vecs[i].pe, vecs[i].data, vecs[i].pbit, vecs[i].sbit, c0);
      repeat (2 * vecs[i].presc) @(negedge CLK);
      perr_model = 1'b0;
      check($sformatf("v%0d_data_valid_cnt", i), dv_cnt - b_dv,     vecs[i].e_dv);
      check($sformatf("v%0d_par_err_o_cnt", i),  perr_cnt - b_perr, vecs[i].e_perr);
      check($sformatf("v%0d_stp_err_cnt", i),    stp_cnt - b_stp,   vecs[i].e_stp);
      check($sformatf("v%0d_strt_glitch_cnt", i), gl_cnt - b_gl,    vecs[i].e_gl);
      check($sformatf("v%0d_par_chk_en_cycles", i), pchk_cnt - b_pchk, vecs[i].e_pchk);
      check($sformatf("v%0d_p_data", i), int'(P_DATA), int'(vecs[i].e_pdata));
      if (vecs[i].e_dv == 1)
        check($sformatf("v%0d_latency", i), last_dv_cyc - c0, vecs[i].e_lat);
      exp_err += vecs[i].e_perr + vecs[i].e_stp + vecs[i].e_gl;
    end

`ifdef UART_RX_ERR_CNT_EN
    check("err_cnt_total", int'(err_cnt), exp_err);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    check("err_cnt_clear", int'(err_cnt), 0);
`endif

    // Back-to-back frames at Prescale=16 without parity and with no idle gap.
    snap();
    send_frame(16, 1'b0, 8'h3C, 1'b0, 1'b1, c0);
    send_frame(16, 1'b0, 8'hFF, 1'b0, 1'b1, c1);
    repeat (32) @(negedge CLK);
    check("b2b_data_valid_cnt", dv_cnt - b_dv, 2);
    check("b2b_first_p_data",   int'(dv_log[b_dv % 64]), 8'h3C);
    check("b2b_second_p_data",  int'(dv_log[(b_dv + 1) % 64]), 8'hFF);
    check("b2b_par_chk_en",     pchk_cnt - b_pchk, 0);
    check("b2b_errors",         (stp_cnt - b_stp) + (perr_cnt - b_perr) + (gl_cnt - b_gl), 0);
    check("b2b_second_latency", last_dv_cyc - c1, 155);

    // Two-cycle low glitch on an idle line.
    snap();
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 48);
    check("glitch_strt_glitch_cnt", gl_cnt - b_gl, 1);
    check("glitch_no_data_valid",   dv_cnt - b_dv, 0);
    check("glitch_p_data_held",     int'(P_DATA), 8'hFF);

    // Reset in the middle of data bit 4, then a clean frame.
    snap();
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("abort_p_data_cleared", int'(P_DATA), 0);
    RST = 1'b1;
    drive_bit(1'b1, 40);
    check("abort_no_pulse", (dv_cnt - b_dv) + (stp_cnt - b_stp) + (perr_cnt - b_perr) + (gl_cnt - b_gl), 0);
    send_frame(16, 1'b0, 8'h81, 1'b0, 1'b1, c0);
    repeat (32) @(negedge CLK);
    check("abort_data_valid_cnt", dv_cnt - b_dv, 1);
    check("abort_p_data",         int'(P_DATA), 8'h81);
    check("abort_latency",        last_dv_cyc - c0, 155);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
